// File: rtl/apb_master.sv
// APB3 bridge for the RV32I load/store port: decodes four slave windows at 0x1000_0xxx..0x1000_3xxx,
// runs each request as a SETUP/ACCESS transfer and returns a one-cycle ready with read data or error.
module apb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        error,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PENABLE,
  output logic        PSEL0,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PSEL3,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  localparam int NUM_SLAVES = 4;
  localparam int CW         = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [1:0]  idx;
    logic        mapped;
  } req_t;

  state_t  state, state_nxt;
  req_t    req;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [NUM_SLAVES-1:0]        psel;
  logic [NUM_SLAVES-1:0]        pready_v;
  logic [NUM_SLAVES-1:0][31:0]  prdata_v;
  logic                         sel_ready;
  logic [31:0]                  sel_rdata;
  logic                         timed_out;

  assign pready_v  = {PREADY3, PREADY2, PREADY1, PREADY0};
  assign prdata_v  = {PRDATA3, PRDATA2, PRDATA1, PRDATA0};
  assign sel_ready = pready_v[req.idx];
  assign sel_rdata = prdata_v[req.idx];
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      req   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Window 0x10000..0x10003 on addr[31:12] is addr[31:14] == 0x04000 with the slave in addr[13:12].
      if (state == IDLE && transfer)
        req <= '{addr: addr, wdata: wdata, write: write, idx: addr[13:12],
                 mapped: (addr[31:14] == 18'h04000)};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b0;
    error     = 1'b0;
    rdata     = '0;
    case (state)
      IDLE:   if (transfer) state_nxt = SETUP;
      SETUP: begin
        cnt_nxt   = '0;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!req.mapped) begin
          ready     = 1'b1;
          error     = 1'b1;
          state_nxt = IDLE;
        end else if (sel_ready) begin
          ready     = 1'b1;
          rdata     = req.write ? '0 : sel_rdata;
          state_nxt = IDLE;
        end else if (timed_out) begin
          ready     = 1'b1;
          error     = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-hot select held through SETUP and ACCESS; nothing selected for an unmapped address.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_psel
    assign psel[i] = (state != IDLE) && req.mapped && (req.idx == 2'(i));
  end

  assign PSEL0   = psel[0];
  assign PSEL1   = psel[1];
  assign PSEL2   = psel[2];
  assign PSEL3   = psel[3];
  assign PENABLE = (state == ACCESS);
  assign PADDR   = req.addr;
  assign PWDATA  = req.wdata;
  assign PWRITE  = req.write;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-age model of the bridge.
module tb_apb_master;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, transfer, write;
  logic [31:0] addr, wdata, rdata, PADDR, PWDATA;
  logic        ready, error, PWRITE, PENABLE;
  logic        PSEL0, PSEL1, PSEL2, PSEL3;
  logic [3:0][31:0] prd;
  logic [3:0]  prdy;
  logic [3:0]  psel;

  assign psel = {PSEL3, PSEL2, PSEL1, PSEL0};

  apb_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .error(error),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
    .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3),
    .PRDATA0(prd[0]), .PRDATA1(prd[1]), .PRDATA2(prd[2]), .PRDATA3(prd[3]),
    .PREADY0(prdy[0]), .PREADY1(prdy[1]), .PREADY2(prdy[2]), .PREADY3(prdy[3])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave number for an address, -1 when outside the four 4 KiB windows starting at 0x1000_0000.
  function automatic int slave_of(input logic [31:0] a);
    int s;
    s = int'(a[31:12]) - 'h10000;
    return (s >= 0 && s < 4) ? s : -1;
  endfunction

  // Model: a request accepted in cycle T has age 1 at T+1 (SETUP) and age >= 2 while in ACCESS.
  bit          m_busy;
  int          m_age;
  logic [31:0] m_addr, m_wdata;
  logic        m_write;

  always @(negedge clk) begin
    logic [3:0]  e_psel;
    logic        e_pen, e_rdy, e_err;
    logic [31:0] e_rd;
    int          slv;
    if (!reset) begin
      m_busy = 0; m_age = 0; m_addr = '0; m_wdata = '0; m_write = 1'b0;
    end
    e_psel = '0; e_pen = 0; e_rdy = 0; e_err = 0; e_rd = '0;
    slv = slave_of(m_addr);
    if (reset && m_busy) begin
      if (slv >= 0) e_psel[slv] = 1'b1;
      if (m_age >= 2) begin
        e_pen = 1'b1;
        if (slv < 0) begin
          e_rdy = 1; e_err = 1;
        end else if (prdy[slv]) begin
          e_rdy = 1;
          e_rd  = m_write ? 32'h0 : prd[slv];
        end else if (m_age == TIMEOUT + 1) begin
          e_rdy = 1; e_err = 1;
        end
      end
    end
    check("m_psel", {28'h0, psel}, {28'h0, e_psel});
    check("m_penable", {31'h0, PENABLE}, {31'h0, e_pen});
    check("m_ready", {31'h0, ready}, {31'h0, e_rdy});
    check("m_paddr", PADDR, m_addr);
    check("m_pwdata", PWDATA, m_wdata);
    check("m_pwrite", {31'h0, PWRITE}, {31'h0, m_write});
    if (e_rdy) begin
      check("m_error", {31'h0, error}, {31'h0, e_err});
      check("m_rdata", rdata, e_rd);
    end
    if (reset) begin
      if (!m_busy) begin
        if (transfer) begin
          m_busy = 1; m_age = 1; m_addr = addr; m_wdata = wdata; m_write = write;
        end
      end else if (e_rdy) m_busy = 0;
      else m_age++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int p;
    int kind;
    reset = 1'b0; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    prd = '0; prdy = '0;
    repeat (2) cyc();
    smp();
    check("rst_psel", {28'h0, psel}, 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_ready", {30'h0, ready, error}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    cyc(); reset = 1'b1;

    // Store to GPO with zero wait states; addr churn during the transfer must be ignored.
    cyc(); transfer = 1; write = 1; addr = 32'h1000_1004; wdata = 32'hDEAD_BEEF; prdy = 4'b0010;
    cyc(); transfer = 0; addr = 32'h1000_3FFC; wdata = 32'h1111_1111; write = 0;
    smp();
    check("st_setup_psel", {28'h0, psel}, 32'h2);
    check("st_setup_pen", {31'h0, PENABLE}, 32'h0);
    check("st_paddr", PADDR, 32'h1000_1004);
    check("st_pwdata", PWDATA, 32'hDEAD_BEEF);
    check("st_pwrite", {31'h0, PWRITE}, 32'h1);
    cyc(); smp();
    check("st_access_pen", {31'h0, PENABLE}, 32'h1);
    check("st_ready", {31'h0, ready}, 32'h1);
    check("st_error", {31'h0, error}, 32'h0);
    cyc(); smp();
    check("st_after", {27'h0, psel, PENABLE}, 32'h0);

    // Load from UART with three wait states.
    cyc(); transfer = 1; write = 0; addr = 32'h1000_3000; prdy = 4'b0000; prd[3] = 32'h55;
    cyc(); transfer = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(); smp();
      check("ws_ready_low", {31'h0, ready}, 32'h0);
    end
    cyc(); prdy[3] = 1'b1; smp();
    check("ws_ready", {31'h0, ready}, 32'h1);
    check("ws_rdata", rdata, 32'h55);
    check("ws_error", {31'h0, error}, 32'h0);
    cyc(); prdy = '0;

    // Unmapped load: error completion in the first ACCESS cycle, no select.
    transfer = 1; addr = 32'h2000_0000; prdy = 4'b1111; prd = {4{32'hA5A5_A5A5}};
    cyc(); transfer = 0; smp();
    check("um_setup_psel", {28'h0, psel}, 32'h0);
    cyc(); smp();
    check("um_psel", {28'h0, psel}, 32'h0);
    check("um_ready", {31'h0, ready}, 32'h1);
    check("um_error", {31'h0, error}, 32'h1);
    check("um_rdata", rdata, 32'h0);
    cyc();

    // RAM never answers: forced error at T+1+TIMEOUT.
    transfer = 1; addr = 32'h1000_0000; prdy = 4'b0000;
    cyc(); transfer = 0; smp();
    check("to_setup_psel", {28'h0, psel}, 32'h1);
    for (int k = 2; k <= TIMEOUT; k++) begin
      cyc(); smp();
      check("to_wait_ready", {31'h0, ready}, 32'h0);
      check("to_wait_bus", {27'h0, psel, PENABLE}, 32'h3);
    end
    cyc(); smp();
    check("to_ready", {31'h0, ready}, 32'h1);
    check("to_error", {31'h0, error}, 32'h1);
    check("to_bus", {27'h0, psel, PENABLE}, 32'h3);
    cyc(); smp();
    check("to_after", {27'h0, psel, PENABLE}, 32'h0);

    // Back-to-back loads with transfer held.
    cyc(); transfer = 1; addr = 32'h1000_0010; prdy = 4'b1111;
    prd[0] = 32'hCAFE_0000; prd[2] = 32'hCAFE_0002;
    cyc();
    cyc(); addr = 32'h1000_2020; smp();
    check("b2b_ready1", {31'h0, ready}, 32'h1);
    check("b2b_rdata1", rdata, 32'hCAFE_0000);
    cyc(); smp();
    check("b2b_gap", {26'h0, psel, PENABLE, ready}, 32'h0);
    cyc(); smp();
    check("b2b_paddr2", PADDR, 32'h1000_2020);
    check("b2b_psel2", {28'h0, psel}, 32'h4);
    cyc(); transfer = 0; smp();
    check("b2b_ready2", {31'h0, ready}, 32'h1);
    check("b2b_rdata2", rdata, 32'hCAFE_0002);
    cyc();

    // Reset during a stalled ACCESS, then a normal store.
    transfer = 1; write = 1; addr = 32'h1000_1008; wdata = 32'h1234_5678; prdy = 4'b0000;
    cyc(); transfer = 0;
    cyc(); cyc();
    reset = 0; #1;
    check("ra_bus", {27'h0, psel, PENABLE}, 32'h0);
    check("ra_ready", {30'h0, ready, error}, 32'h0);
    check("ra_regs", PADDR | PWDATA | {31'h0, PWRITE}, 32'h0);
    cyc(); cyc(); reset = 1;
    cyc(); transfer = 1; prdy = 4'b0010;
    cyc(); transfer = 0;
    cyc(); smp();
    check("ra_store_ready", {31'h0, ready}, 32'h1);
    check("ra_store_error", {31'h0, error}, 32'h0);
    cyc();

    // Random traffic; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      cyc();
      p = ((c / 150) % 3 == 0) ? 75 : ((c / 150) % 3 == 1) ? 25 : 0;
      transfer = ($urandom_range(0, 3) != 0);
      write    = $urandom_range(0, 1) == 1;
      wdata    = $urandom;
      kind     = $urandom_range(0, 6);
      case (kind)
        4:       addr = $urandom;
        5:       addr = {20'h10004, 12'($urandom)};
        6:       addr = {20'h0FFFF, 12'($urandom)};
        default: addr = {20'h10000 + 20'(kind), 12'($urandom)};
      endcase
      for (int s = 0; s < 4; s++) begin
        prd[s]  = $urandom;
        prdy[s] = ($urandom_range(0, 99) < p);
      end
      reset = ($urandom_range(0, 599) != 0);
    end
    cyc(); reset = 1; transfer = 0;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
